// File: rtl/mouse_port_pkg.sv
// Shared constants for the BK 177714 mouse port.
// Bit positions of the state word and FSM states.
package bk_pkg;

    localparam int MP_UP      = 0;
    localparam int MP_RIGHT   = 1;
    localparam int MP_DOWN    = 2;
    localparam int MP_LEFT    = 3;
    localparam int MP_BTN_L   = 5;
    localparam int MP_BTN_R   = 6;
    localparam int MP_ENA_BIT = 3;

    typedef enum logic [1:0] {
        MP_IDLE,
        MP_APPLY,
        MP_EMIT
    } mp_state_e;

endpackage

// File: rtl/mouse_port_if.sv
// Bus and ps2_mouse signals seen by the mouse port.
// master drives the inputs, slave is the port itself.
interface mouse_port_if;

    logic [7:0]  pkt_cnt;
    logic [8:0]  dx;
    logic [8:0]  dy;
    logic        btn_l;
    logic        btn_r;
    logic        sel;
    logic        stb;
    logic        we;
    logic        wtbt0;
    logic [15:0] din;
    logic [15:0] dout;
    logic        active;

    modport master (
        output pkt_cnt, dx, dy,
        output btn_l, btn_r,
        output sel, stb, we, wtbt0, din,
        input  dout, active
    );

    modport slave (
        input  pkt_cnt, dx, dy,
        input  btn_l, btn_r,
        input  sel, stb, we, wtbt0, din,
        output dout, active
    );

endinterface

// File: rtl/mouse_port_axis.sv
// One motion axis: saturating accumulator that
// emits a one-shot pos/neg flag per THRESH counts.
import bk_pkg::*;

module mouse_axis #(
    parameter int THRESH = 4,
    parameter int ACC_W  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       add_en,
    input  logic [8:0] d,
    input  logic       emit_en,
    input  logic       clr_flags,
    output logic       pos,
    output logic       neg
);

    localparam logic signed [ACC_W:0] W_MAX =
        (ACC_W+1)'(2**(ACC_W-1)-1);
    localparam logic signed [ACC_W:0] W_MIN = -W_MAX;
    localparam logic signed [ACC_W-1:0] W_TH =
        ACC_W'(THRESH);

    logic signed [ACC_W-1:0] r_acc;
    logic                    r_pos;
    logic                    r_neg;
    logic signed [ACC_W:0]   w_sum;
    logic signed [ACC_W-1:0] w_sat;

    assign w_sum = {r_acc[ACC_W-1], r_acc}
                 + {{(ACC_W-8){d[8]}}, d};

    always_comb begin
        if (w_sum > W_MAX)
            w_sat = W_MAX[ACC_W-1:0];
        else if (w_sum < W_MIN)
            w_sat = W_MIN[ACC_W-1:0];
        else
            w_sat = w_sum[ACC_W-1:0];
    end

    // A set flag blocks further emits but not accumulation.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_acc <= '0;
            r_pos <= 1'b0;
            r_neg <= 1'b0;
        end else begin
            if (clr_flags) begin
                r_pos <= 1'b0;
                r_neg <= 1'b0;
            end
            if (add_en) begin
                r_acc <= w_sat;
            end else if (emit_en && !r_pos && !r_neg) begin
                if (r_acc >= W_TH) begin
                    r_pos <= 1'b1;
                    r_acc <= r_acc - W_TH;
                end else if (r_acc <= -W_TH) begin
                    r_neg <= 1'b1;
                    r_acc <= r_acc + W_TH;
                end
            end
        end
    end

    assign pos = r_pos;
    assign neg = r_neg;

endmodule

// File: rtl/mouse_port.sv
// BK 177714 mouse state word built from ps2_mouse
// packets: per-axis step flags plus synced buttons.
import bk_pkg::*;

module mouse_port #(
    parameter int THRESH = 4,
    parameter int ACC_W  = 10
) (
    input  logic         clk,
    input  logic         reset,
    mouse_port_if.slave  bus
);

    mp_state_e   r_state;
    logic [7:0]  r_last_cnt;
    logic [8:0]  r_dx;
    logic [8:0]  r_dy;
    logic        r_enable;
    logic        r_rd_d;
    logic        r_bl1, r_bl2;
    logic        r_br1, r_br2;

    logic        w_wr;
    logic        w_rd;
    logic        w_rd_fall;
    logic        w_clr;
    logic        w_add;
    logic        w_emit;
    logic        w_xp, w_xn;
    logic        w_yp, w_yn;
    logic [15:0] w_word;
    logic        w_unused;

    assign w_wr = bus.stb & bus.sel
                & bus.we & bus.wtbt0;
    assign w_rd = bus.stb & bus.sel & ~bus.we;
    assign w_rd_fall = r_rd_d & ~w_rd;
    assign w_clr = w_wr & ~bus.din[MP_ENA_BIT];

    // A write during APPLY/EMIT cancels the packet.
    assign w_add  = (r_state == MP_APPLY)
                  & r_enable & ~w_wr;
    assign w_emit = (r_state == MP_EMIT)
                  & r_enable & ~w_wr;

    assign w_unused = ^{bus.din[15:4], bus.din[2:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= MP_IDLE;
            r_last_cnt <= bus.pkt_cnt;
            r_dx       <= '0;
            r_dy       <= '0;
        end else begin
            unique case (r_state)
                MP_IDLE: begin
                    if (bus.pkt_cnt != r_last_cnt) begin
                        r_last_cnt <= bus.pkt_cnt;
                        r_dx       <= bus.dx;
                        r_dy       <= bus.dy;
                        r_state    <= MP_APPLY;
                    end
                end
                MP_APPLY: r_state <= MP_EMIT;
                MP_EMIT:  r_state <= MP_IDLE;
                default:  r_state <= MP_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_enable <= 1'b0;
            r_rd_d   <= 1'b0;
            r_bl1    <= 1'b0;
            r_bl2    <= 1'b0;
            r_br1    <= 1'b0;
            r_br2    <= 1'b0;
        end else begin
            if (w_wr)
                r_enable <= bus.din[MP_ENA_BIT];
            r_rd_d <= w_rd;
            r_bl1  <= bus.btn_l;
            r_bl2  <= r_bl1;
            r_br1  <= bus.btn_r;
            r_br2  <= r_br1;
        end
    end

    mouse_axis #(
        .THRESH (THRESH),
        .ACC_W  (ACC_W)
    ) u_ax (
        .clk       (clk),
        .reset     (reset),
        .clr       (w_clr),
        .add_en    (w_add),
        .d         (r_dx),
        .emit_en   (w_emit),
        .clr_flags (w_rd_fall),
        .pos       (w_xp),
        .neg       (w_xn)
    );

    mouse_axis #(
        .THRESH (THRESH),
        .ACC_W  (ACC_W)
    ) u_ay (
        .clk       (clk),
        .reset     (reset),
        .clr       (w_clr),
        .add_en    (w_add),
        .d         (r_dy),
        .emit_en   (w_emit),
        .clr_flags (w_rd_fall),
        .pos       (w_yp),
        .neg       (w_yn)
    );

    always_comb begin
        w_word           = '0;
        w_word[MP_UP]    = w_yp;
        w_word[MP_RIGHT] = w_xp;
        w_word[MP_DOWN]  = w_yn;
        w_word[MP_LEFT]  = w_xn;
        w_word[MP_BTN_L] = r_bl2;
        w_word[MP_BTN_R] = r_br2;
    end

    assign bus.dout   = bus.sel ? w_word : 16'd0;
    assign bus.active = (r_state == MP_APPLY);

endmodule

// File: tb/tb_mouse_port.sv
// Randomized scoreboard bench for mouse_port against
// an arithmetic model of the port's state word.
module tb_mouse_port;

    localparam int TH   = 4;
    localparam int AMAX = 511;

    typedef struct {
        logic [15:0] w;
        int          ax;
        int          ay;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mouse_port_if bus();

    mouse_port #(
        .THRESH (TH),
        .ACC_W  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t q[$];
    exp_t mon_e;

    int         m_ax, m_ay;
    logic [3:0] m_fl;
    logic       m_en, m_bl, m_br;

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s actual=%0d required=%0d",
                     nm, act, exp);
    endtask

    function automatic int sat(int v);
        if (v > AMAX) return AMAX;
        if (v < -AMAX) return -AMAX;
        return v;
    endfunction

    function automatic logic [15:0] m_word();
        return {9'd0, m_br, m_bl, 1'b0, m_fl};
    endfunction

    task automatic model_clear();
        m_ax = 0;
        m_ay = 0;
        m_fl = '0;
    endtask

    task automatic model_pkt(int dx, int dy);
        if (!m_en) return;
        m_ax = sat(m_ax + dx);
        m_ay = sat(m_ay + dy);
        if (!m_fl[1] && !m_fl[3]) begin
            if (m_ax >= TH) begin
                m_fl[1] = 1'b1;
                m_ax -= TH;
            end else if (m_ax <= -TH) begin
                m_fl[3] = 1'b1;
                m_ax += TH;
            end
        end
        if (!m_fl[0] && !m_fl[2]) begin
            if (m_ay >= TH) begin
                m_fl[0] = 1'b1;
                m_ay -= TH;
            end else if (m_ay <= -TH) begin
                m_fl[2] = 1'b1;
                m_ay += TH;
            end
        end
    endtask

    // Every CPU read cycle is compared against the queue.
    always @(negedge clk) begin
        if (!reset && bus.sel && bus.stb && !bus.we) begin
            if (q.size() == 0) begin
                chk("rd_unexpected", 1, 0);
            end else begin
                mon_e = q.pop_front();
                chk("rd_word", int'(bus.dout), int'(mon_e.w));
                chk("acc_x", int'(dut.u_ax.r_acc), mon_e.ax);
                chk("acc_y", int'(dut.u_ay.r_acc), mon_e.ay);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pkt(int dx, int dy);
        int na = 0;
        bus.pkt_cnt = bus.pkt_cnt + 8'($urandom_range(1, 3));
        bus.dx = 9'(dx);
        bus.dy = 9'(dy);
        for (int i = 0; i < 4; i++) begin
            tick();
            na += int'(bus.active);
        end
        chk("active_pulse", na, 1);
        model_pkt(dx, dy);
    endtask

    task automatic rd();
        exp_t e;
        e.w  = m_word();
        e.ax = m_ax;
        e.ay = m_ay;
        q.push_back(e);
        bus.sel = 1'b1;
        bus.stb = 1'b1;
        bus.we  = 1'b0;
        tick();
        bus.stb = 1'b0;
        tick();
        m_fl = '0;
    endtask

    task automatic wr(logic [15:0] d, logic bt0);
        bus.sel   = 1'b1;
        bus.stb   = 1'b1;
        bus.we    = 1'b1;
        bus.wtbt0 = bt0;
        bus.din   = d;
        tick();
        bus.stb = 1'b0;
        bus.we  = 1'b0;
        tick();
        if (bt0) begin
            m_en = d[3];
            if (!d[3]) model_clear();
        end
    endtask

    task automatic btn(logic l, logic r);
        bus.btn_l = l;
        bus.btn_r = r;
        tick();
        tick();
        tick();
        m_bl = l;
        m_br = r;
    endtask

    int          op;
    logic [15:0] rdin;

    initial begin
        bus.pkt_cnt = 8'h37;
        bus.dx      = '0;
        bus.dy      = '0;
        bus.btn_l   = 1'b0;
        bus.btn_r   = 1'b0;
        bus.sel     = 1'b1;
        bus.stb     = 1'b0;
        bus.we      = 1'b0;
        bus.wtbt0   = 1'b1;
        bus.din     = '0;
        m_en = 1'b0;
        m_bl = 1'b0;
        m_br = 1'b0;
        model_clear();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("reset_dout", int'(bus.dout), 0);
        chk("reset_active", int'(bus.active), 0);
        rd();

        // dy=+4: flag visible exactly 3 clocks after the packet
        wr(16'h0008, 1'b1);
        bus.pkt_cnt = bus.pkt_cnt + 8'd1;
        bus.dx = 9'd0;
        bus.dy = 9'd4;
        tick();
        tick();
        chk("lat_2clk", int'(bus.dout[0]), 0);
        tick();
        chk("lat_3clk", int'(bus.dout[0]), 1);
        tick();
        model_pkt(0, 4);
        rd();
        rd();

        pkt(-9, 0);
        rd();
        pkt(0, 0);
        rd();

        wr(16'h0000, 1'b1);
        pkt(100, 0);
        rd();
        wr(16'h0008, 1'b1);
        rd();

        for (int i = 0; i < 8; i++) pkt(0, 255);
        rd();
        wr(16'h0000, 1'b1);
        wr(16'h0008, 1'b1);
        for (int i = 0; i < 8; i++) pkt(-256, -256);
        rd();

        // button synchronizer latency
        bus.btn_l = 1'b1;
        tick();
        chk("btn_l_1clk", int'(bus.dout[5]), 0);
        tick();
        chk("btn_l_2clk", int'(bus.dout[5]), 1);
        tick();
        m_bl = 1'b1;
        btn(1'b0, 1'b1);
        pkt(-20, 20);
        bus.sel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("nosel_dout", int'(bus.dout), 0);
        end
        bus.sel = 1'b1;
        tick();
        rd();

        // write clearing during APPLY drops the packet
        wr(16'h0008, 1'b1);
        pkt(30, -30);
        bus.pkt_cnt = bus.pkt_cnt + 8'd1;
        bus.dx = 9'd8;
        bus.dy = 9'd0;
        tick();
        bus.stb   = 1'b1;
        bus.we    = 1'b1;
        bus.wtbt0 = 1'b1;
        bus.din   = 16'h0000;
        tick();
        bus.stb = 1'b0;
        bus.we  = 1'b0;
        tick();
        tick();
        m_en = 1'b0;
        model_clear();
        rd();

        // reset while in EMIT
        wr(16'h0008, 1'b1);
        pkt(7, 0);
        bus.pkt_cnt = bus.pkt_cnt + 8'd1;
        bus.dx = 9'd8;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        m_en = 1'b0;
        model_clear();
        rd();

        wr(16'h0008, 1'b1);
        for (int i = 0; i < 200; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 5) begin
                pkt(int'($urandom_range(0, 511)) - 256,
                    int'($urandom_range(0, 511)) - 256);
            end else if (op <= 7) begin
                rd();
            end else if (op == 8) begin
                rdin = 16'($urandom);
                rdin[3] = ($urandom_range(0, 3) != 0);
                wr(rdin, 1'($urandom_range(0, 1)));
            end else begin
                btn(1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
            end
        end
        rd();
        tick();
        chk("queue_empty", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
